iq_addsub_pipe: RTL and testbench
=================================

IQ_ADDSUB_PIPE -- requirements
Module: iq_addsub_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, the signed sample width of i, q and sum (minimum 4).
REQ-002 SHALL provide parameter COUNT_W, default 16, the width of sample_count.
REQ-003 SHALL provide port M100CLK  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port in_valid  input  1  the i/q/op/scale_mode inputs hold a sample.
REQ-006 SHALL provide port in_ready  output  1  the block accepts a sample this cycle.
REQ-007 SHALL provide port i  input  WIDTH  signed operand A.
REQ-008 SHALL provide port q  input  WIDTH  signed operand B.
REQ-009 SHALL provide port op  input  1  per-sample operation: 0 = i-q, 1 = i+q.
REQ-010 SHALL provide port scale_mode  input  2  per-sample scaling: 00 halve-floor, 01 halve-round, 10 saturate, 11 wrap.
REQ-011 SHALL provide port out_valid  output  1  sum and overflow hold a result.
REQ-012 SHALL provide port out_ready  input  1  the downstream consumer accepts the result.
REQ-013 SHALL provide port sum  output  WIDTH  signed result.
REQ-014 SHALL provide port overflow  output  1  the result was clamped or wrapped; qualified by out_valid.
REQ-015 SHALL provide port sample_count  output  COUNT_W  count of completed output transfers.

Function
REQ-016 SHALL accept an input when in_valid && in_ready, and complete an output transfer when out_valid && out_ready.
REQ-017 SHALL use a two-stage pipeline: stage 1 registers the (WIDTH+1)-bit signed full result plus op and scale_mode; stage 2 registers the scaled sum and overflow.
REQ-018 SHALL produce out_valid exactly 2 cycles after acceptance when there is no stall.
REQ-019 SHALL advance the pipeline when (!out_valid || out_ready): stage 2 loads from stage 1, and stage 1 loads from the input.
REQ-020 SHALL drive in_ready = (!out_valid || out_ready), combinationally, with no combinational path from in_valid.
REQ-021 SHALL hold sum, overflow and all stage contents unchanged while out_valid && !out_ready.
REQ-022 SHALL carry a valid bit in each stage; a bubble (in_valid=0 on advance) SHALL propagate as out_valid=0.
REQ-023 SHALL sign-extend both operands to WIDTH+1 bits before the add or subtract, so the full result is exact.
REQ-024 SHALL, in halve-floor mode, output full>>>1 (arithmetic shift) with overflow=0.
REQ-025 SHALL, in halve-round mode, output (full+1)>>>1 computed in WIDTH+2 bits.
REQ-026 SHALL, in halve-round mode, clamp a result of +2^(WIDTH-1) to 2^(WIDTH-1)-1 and set overflow=1.
REQ-027 SHALL, in saturate mode, clamp full to [-2^(WIDTH-1), 2^(WIDTH-1)-1], with overflow=1 if and only if clamping occurred.
REQ-028 SHALL, in wrap mode, output full[WIDTH-1:0], with overflow=1 if and only if full is outside the WIDTH-bit signed range.
REQ-029 SHALL increment sample_count by 1 on each output transfer, wrapping from all-ones to 0.
REQ-030 SHALL, when an input is accepted and an output completes in the same cycle, perform both, with no loss or duplication.
REQ-031 SHALL sample op and scale_mode with their own sample only; changing them does not affect samples already in flight.

Reset
REQ-032 SHALL, while reset=0, asynchronously clear both stage valid bits, out_valid, sum, overflow and sample_count to 0.
REQ-033 SHALL discard any in-flight samples on reset; nothing accepted before reset is ever output.
REQ-034 SHALL drive in_ready=1 during reset and after release, since out_valid=0.
REQ-035 SHALL accept a new sample on the first rising edge after reset deasserts (synchronous release).

Verification (WIDTH=8)
REQ-036 SHALL verify subtract with saturate: i=127, q=-128, op=0, mode=10 -> 2 cycles later sum=127, overflow=1; with mode=11 -> sum=-1, overflow=1.
REQ-037 SHALL verify halving: i=-3, q=0, op=1, mode=00 -> sum=-2, overflow=0; mode=01 -> sum=-1.
REQ-038 SHALL verify the round clamp: i=127, q=-128, op=0, mode=01 -> full=255, sum=127, overflow=1.
REQ-039 SHALL verify backpressure: 5 back-to-back samples with out_ready=0 from cycle 3 to 6 -> in_ready=0 while out_valid=1; all 5 results emerge in order, with none lost or duplicated, and sample_count=5.
REQ-040 SHALL verify reset mid-operation: assert reset=0 with 2 samples in flight -> out_valid=0 and sample_count=0 immediately; no stale output after release.
REQ-041 SHALL verify counter wrap: with COUNT_W=4, 17 transfers -> sample_count=1.

Source files
------------

// File: rtl/iq_addsub_pipe.sv
// ============================================================================
// Module      : iq_addsub_pipe
// Description : Two-stage I/Q add/subtract pipeline with valid/ready flow
//               control, selectable halving/saturating/wrapping output
//               scaling and a count of completed output transfers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_addsub_pipe #(
   parameter int WIDTH   = 32,
   parameter int COUNT_W = 16
) (
   input  logic                      M100CLK,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [WIDTH-1:0]   i,
   input  logic signed [WIDTH-1:0]   q,
   input  logic                      op,
   input  logic [1:0]                scale_mode,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [WIDTH-1:0]   sum,
   output logic                      overflow,
   output logic [COUNT_W-1:0]        sample_count
);

   localparam logic [1:0]         c_MODE_FLOOR = 2'b00;
   localparam logic [1:0]         c_MODE_ROUND = 2'b01;
   localparam logic [1:0]         c_MODE_SAT   = 2'b10;
   localparam logic [WIDTH-1:0]   c_MAX        = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]   c_MIN        = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [COUNT_W-1:0] c_CNT_ONE    = {{(COUNT_W-1){1'b0}}, 1'b1};

   logic                 w_adv;
   logic [WIDTH:0]       w_a;
   logic [WIDTH:0]       w_b;
   logic [WIDTH:0]       w_full;
   logic [WIDTH:0]       w_floor;
   logic [WIDTH:0]       w_round;
   logic [WIDTH-1:0]     w_sum;
   logic                 w_ovf;

   logic                 r_s1_valid;
   logic [WIDTH:0]       r_s1_full;
   logic [1:0]           r_s1_mode;

   // The whole pipeline moves together whenever the output slot is free
   // or being drained; ready therefore never depends on in_valid.
   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   // One guard bit makes the add/subtract exact for any operand pair.
   assign w_a    = {i[WIDTH-1], i};
   assign w_b    = {q[WIDTH-1], q};
   assign w_full = op ? (w_a + w_b) : (w_a - w_b);

   // (full+1)>>>1 equals floor(full/2) plus the dropped LSB, which keeps the
   // rounding adder one bit narrower while giving the identical result.
   assign w_floor = {r_s1_full[WIDTH], r_s1_full[WIDTH:1]};
   assign w_round = w_floor + {{WIDTH{1'b0}}, r_s1_full[0]};

   // Stage 1: capture the exact result and this sample's scaling mode.
   // The operation is already folded into the full result.
   always_ff @(posedge M100CLK or negedge reset) begin
      if (!reset) begin
         r_s1_valid <= 1'b0;
         r_s1_full  <= '0;
         r_s1_mode  <= '0;
      end else if (w_adv) begin
         r_s1_valid <= in_valid;
         r_s1_full  <= w_full;
         r_s1_mode  <= scale_mode;
      end
   end

   // Scale the stage-1 result into WIDTH bits and flag clamping/wrapping.
   always_comb begin
      w_sum = w_floor[WIDTH-1:0];
      w_ovf = 1'b0;
      case (r_s1_mode)
         c_MODE_FLOOR: begin
            w_sum = w_floor[WIDTH-1:0];
         end
         c_MODE_ROUND: begin
            // Only the most positive full result can round up past the range.
            if (w_round[WIDTH] != w_round[WIDTH-1]) begin
               w_sum = c_MAX;
               w_ovf = 1'b1;
            end else begin
               w_sum = w_round[WIDTH-1:0];
            end
         end
         c_MODE_SAT: begin
            if (r_s1_full[WIDTH] != r_s1_full[WIDTH-1]) begin
               w_sum = r_s1_full[WIDTH] ? c_MIN : c_MAX;
               w_ovf = 1'b1;
            end else begin
               w_sum = r_s1_full[WIDTH-1:0];
            end
         end
         default: begin
            w_sum = r_s1_full[WIDTH-1:0];
            w_ovf = (r_s1_full[WIDTH] != r_s1_full[WIDTH-1]);
         end
      endcase
   end

   // Stage 2: output register, frozen while the consumer stalls.
   always_ff @(posedge M100CLK or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         sum       <= '0;
         overflow  <= 1'b0;
      end else if (w_adv) begin
         out_valid <= r_s1_valid;
         sum       <= w_sum;
         overflow  <= w_ovf;
      end
   end

   // Count completed output transfers, wrapping naturally.
   always_ff @(posedge M100CLK or negedge reset) begin
      if (!reset) begin
         sample_count <= '0;
      end else if (out_valid && out_ready) begin
         sample_count <= sample_count + c_CNT_ONE;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_iq_addsub_pipe.sv
// ============================================================================
// Module      : tb_iq_addsub_pipe
// Description : Self-checking bench for iq_addsub_pipe (WIDTH=8, COUNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iq_addsub_pipe;

   localparam int WIDTH   = 8;
   localparam int COUNT_W = 4;
   localparam int MAXV    = 127;
   localparam int MINV    = -128;

   typedef struct {
      int s;
      bit ov;
   } exp_t;

   logic                     M100CLK;
   logic                     reset;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [WIDTH-1:0]  i;
   logic signed [WIDTH-1:0]  q;
   logic                     op;
   logic [1:0]               scale_mode;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [WIDTH-1:0]  sum;
   logic                     overflow;
   logic [COUNT_W-1:0]       sample_count;

   int errors = 0;
   int checks = 0;

   iq_addsub_pipe #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
      .M100CLK      (M100CLK),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .i            (i),
      .q            (q),
      .op           (op),
      .scale_mode   (scale_mode),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .sum          (sum),
      .overflow     (overflow),
      .sample_count (sample_count)
   );

   initial M100CLK = 1'b0;
   always #5 M100CLK = ~M100CLK;

   // floor(x/2) with plain integer arithmetic
   function automatic int fdiv2(input int x);
      return (x >= 0) ? x / 2 : -((1 - x) / 2);
   endfunction

   // Reference model: exact result, then the scaling rule of the mode
   function automatic exp_t model(input int a, input int b, input bit opv, input bit [1:0] m);
      exp_t e;
      int   full;
      full = opv ? a + b : a - b;
      e.ov = 1'b0;
      case (m)
         2'd0: e.s = fdiv2(full);
         2'd1: begin
            e.s = fdiv2(full + 1);
            if (e.s > MAXV) begin e.s = MAXV; e.ov = 1'b1; end
         end
         2'd2: begin
            e.s = full;
            if (full > MAXV) begin e.s = MAXV; e.ov = 1'b1; end
            else if (full < MINV) begin e.s = MINV; e.ov = 1'b1; end
         end
         default: begin
            e.s = full;
            if (full > MAXV) begin e.s = full - 256; e.ov = 1'b1; end
            else if (full < MINV) begin e.s = full + 256; e.ov = 1'b1; end
         end
      endcase
      return e;
   endfunction

   function automatic logic [7:0] pick_operand();
      case ($urandom_range(0, 3))
         0: return 8'd127;
         1: return 8'h80;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic drive_random();
      i          = pick_operand();
      q          = pick_operand();
      op         = 1'($urandom);
      scale_mode = 2'($urandom);
   endtask

   // Pulse reset, releasing it just after a rising edge
   task automatic do_reset();
      @(posedge M100CLK);
      #2 reset = 1'b0;
      in_valid  = 1'b0;
      #4;
      @(posedge M100CLK);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      i = '0; q = '0; op = 1'b0; scale_mode = 2'b00;
      #12;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (sample_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", sample_count); end
      checks++; if (sum !== 8'sd0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_sum_ovf: got %0d/%b want 0/0", sum, overflow); end
      @(posedge M100CLK);
      #1 reset = 1'b1;
      // first edge after release must accept
      in_valid = 1'b1; i = 8'sd10; q = 8'sd5; op = 1'b1; scale_mode = 2'b11;
      @(posedge M100CLK);
      #1 in_valid = 1'b0;
      @(posedge M100CLK);
      @(negedge M100CLK);
      checks++; if (out_valid !== 1'b1 || int'(sum) !== 15) begin errors++; $display("FAIL first_after_release: got v=%b sum=%0d want v=1 sum=15", out_valid, sum); end
      out_ready = 1'b1;
      @(posedge M100CLK);
      #1;
   endtask

   task automatic test_directed();
      int   vi[5] = '{127, 127, -3, -3, 127};
      int   vq[5] = '{-128, -128, 0, 0, -128};
      bit   vo[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      int   vm[5] = '{2, 3, 0, 1, 1};
      int   es[5] = '{127, -1, -2, -1, 127};
      bit   eo[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 5; k++) begin
         @(posedge M100CLK);
         #1 out_ready = 1'b1; in_valid = 1'b1;
         i = 8'(vi[k]); q = 8'(vq[k]); op = vo[k]; scale_mode = 2'(vm[k]);
         @(posedge M100CLK);
         #1 in_valid = 1'b0;
         @(negedge M100CLK);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early[%0d]: out_valid=%b want 0", k, out_valid); end
         @(negedge M100CLK);
         checks++;
         if (out_valid !== 1'b1 || int'(sum) !== es[k] || overflow !== eo[k]) begin
            errors++;
            $display("FAIL directed[%0d]: got v=%b sum=%0d ovf=%b want v=1 sum=%0d ovf=%b", k, out_valid, sum, overflow, es[k], eo[k]);
         end
      end
      @(posedge M100CLK);
      #1;
   endtask

   task automatic test_backpressure();
      exp_t exp_q[5];
      int   n   = 0;
      int   got = 0;
      do_reset();
      for (int cyc = 1; cyc <= 20; cyc++) begin
         if (cyc > 1) begin @(posedge M100CLK); #1; end
         out_ready = !(cyc >= 3 && cyc <= 6);
         if (n < 5) begin
            in_valid = 1'b1; i = 8'(n * 20 + 3); q = 8'(n - 2); op = 1'b1; scale_mode = 2'b11;
            exp_q[n] = model(int'(i), int'(q), op, scale_mode);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge M100CLK);
         if (out_valid && !out_ready) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", cyc, in_ready); end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (got >= 5) begin
               errors++; $display("FAIL bp_duplicate: extra output sum=%0d want none", sum);
            end else if (int'(sum) !== exp_q[got].s || overflow !== exp_q[got].ov) begin
               errors++; $display("FAIL bp_data[%0d]: got %0d/%b want %0d/%b", got, sum, overflow, exp_q[got].s, exp_q[got].ov);
            end
            got++;
         end
         if (in_valid && in_ready) n++;
      end
      checks++; if (got !== 5) begin errors++; $display("FAIL bp_count_out: got %0d want 5", got); end
      checks++; if (sample_count !== 4'd5) begin errors++; $display("FAIL bp_sample_count: got %0d want 5", sample_count); end
   endtask

   task automatic test_reset_mid();
      @(posedge M100CLK);
      #1 out_ready = 1'b1; in_valid = 1'b1; i = 8'sd7; q = 8'sd1; op = 1'b0; scale_mode = 2'b10;
      @(posedge M100CLK);
      #1 i = 8'sd9;
      @(posedge M100CLK);
      #2;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
      reset = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || sample_count !== 4'd0) begin errors++; $display("FAIL mid_reset: got v=%b cnt=%0d want v=0 cnt=0", out_valid, sample_count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
      in_valid = 1'b0;
      @(posedge M100CLK);
      #1 reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge M100CLK);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: out_valid=%b want 0", c, out_valid); end
      end
   endtask

   task automatic test_wrap();
      exp_t sb[$];
      exp_t e;
      int   acc = 0;
      int   xfers = 0;
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 25; c++) begin
         if (c > 0) begin @(posedge M100CLK); #1; end
         in_valid = (acc < 17);
         drive_random();
         @(negedge M100CLK);
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL wrap_spurious: sum=%0d want no output", sum);
            end else begin
               e = sb.pop_front();
               if (int'(sum) !== e.s || overflow !== e.ov) begin errors++; $display("FAIL wrap_data: got %0d/%b want %0d/%b", sum, overflow, e.s, e.ov); end
            end
            xfers++;
         end
         if (in_valid && in_ready) begin sb.push_back(model(int'(i), int'(q), op, scale_mode)); acc++; end
      end
      checks++; if (xfers !== 17) begin errors++; $display("FAIL wrap_xfers: got %0d want 17", xfers); end
      checks++; if (sample_count !== 4'd1) begin errors++; $display("FAIL wrap_count: got %0d want 1", sample_count); end
   endtask

   task automatic test_random();
      exp_t sb[$];
      exp_t e;
      int   exp_count = 0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if (c > 0) begin @(posedge M100CLK); #1; end
         if (c < 390) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
         end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         drive_random();
         @(negedge M100CLK);
         checks++;
         if (in_ready !== (!out_valid || out_ready)) begin
            errors++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, (!out_valid || out_ready));
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL rnd_spurious c%0d: sum=%0d want no output", c, sum);
            end else begin
               e = sb.pop_front();
               if (int'(sum) !== e.s || overflow !== e.ov) begin errors++; $display("FAIL rnd_data c%0d: got %0d/%b want %0d/%b", c, sum, overflow, e.s, e.ov); end
            end
            exp_count++;
         end
         if (in_valid && in_ready) sb.push_back(model(int'(i), int'(q), op, scale_mode));
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL rnd_lost: %0d results missing want 0", sb.size()); end
      checks++; if (sample_count !== 4'(exp_count)) begin errors++; $display("FAIL rnd_count: got %0d want %0d", sample_count, 4'(exp_count)); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
